nv_cdc_hs_tx: RTL and testbench

- Source-side transmitter of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts a data word on a valid/ready interface in the nvdla_core_clk domain.
- Drives a glitch-free registered request level, plus a bundled data bus that is held stable across the crossing.
- The destination samples cdc_req through a 3-flop synchronizer and returns cdc_ack. This block synchronizes cdc_ack internally and completes the four phases before accepting the next word.

---
 rtl/nv_cdc_hs_tx_if.sv | 20 ++
 rtl/nv_cdc_hs_tx.sv | 92 +++++++++
 tb/tb_nv_cdc_hs_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/nv_cdc_hs_tx_if.sv
// Source-side valid/ready word interface feeding the CDC handshake transmitter.
interface nv_cdc_hs_tx_if #(
    parameter int DW = 32
);
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] src_data;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/nv_cdc_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake: registered req level,
// bundled data held from accept to the next accept, internal ack synchronizer.
module nv_cdc_hs_tx #(
    parameter int DW              = 32,
    parameter int ACK_SYNC_STAGES = 3
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    nv_cdc_hs_tx_if.slave       src,
    output logic                cdc_req,
    output logic [DW-1:0]       cdc_data,
    input  logic                cdc_ack,
    output logic                tx_done,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_t;

    state_t                     state;
    logic [ACK_SYNC_STAGES-1:0] ack_sync;
    logic                       ack_s;
    logic                       ready_q;
    logic                       busy_q;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], cdc_ack};
        end
    end

    assign ack_s = ack_sync[ACK_SYNC_STAGES-1];

    // ready/busy are registered alongside state so they equal decodes of it
    // without any path from src_valid.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            cdc_req  <= 1'b0;
            cdc_data <= '0;
            tx_done  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (src.src_valid) begin
                        cdc_data <= src.src_data;
                        state    <= SETUP;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                SETUP: begin
                    cdc_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        cdc_req <= 1'b0;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cdc_req <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign src.src_ready = ready_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_nv_cdc_hs_tx.sv
// Self-checking bench for nv_cdc_hs_tx: directed table, corner sequences, random vs model.
module tb_nv_cdc_hs_tx;

    localparam int DW = 32;
    localparam int S  = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cdc_req;
    logic [DW-1:0] cdc_data;
    logic          cdc_ack;
    logic          tx_done;
    logic          busy;

    nv_cdc_hs_tx_if #(.DW(DW)) src_if ();

    nv_cdc_hs_tx #(.DW(DW), .ACK_SYNC_STAGES(S)) u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .src            (src_if.slave),
        .cdc_req        (cdc_req),
        .cdc_data       (cdc_data),
        .cdc_ack        (cdc_ack),
        .tx_done        (tx_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction view with the ack seen S edges late.
    bit          m_busy, m_setup, m_req, m_done;
    logic [31:0] m_data;
    bit          ackq[$];

    task automatic model_reset();
        m_busy = 0; m_setup = 0; m_req = 0; m_done = 0; m_data = '0;
        ackq.delete();
        for (int i = 0; i < S; i++) ackq.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit a);
        bit as;
        as = ackq.pop_front();
        ackq.push_back(a);
        m_done = 0;
        if (!m_busy) begin
            if (v) begin m_busy = 1; m_setup = 1; m_data = d; end
        end else if (m_setup) begin
            m_setup = 0; m_req = 1;
        end else if (m_req) begin
            if (as) m_req = 0;
        end else if (!as) begin
            m_busy = 0; m_done = 1;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit a);
        src_if.src_valid = v;
        src_if.src_data  = d;
        cdc_ack          = a;
        @(posedge clk);
        model_step(v, d, a);
        @(negedge clk);
        chk("model_ready", {63'd0, src_if.src_ready}, {63'd0, !m_busy});
        chk("model_req",   {63'd0, cdc_req},          {63'd0, m_req});
        chk("model_data",  {32'd0, cdc_data},         {32'd0, m_data});
        chk("model_done",  {63'd0, tx_done},          {63'd0, m_done});
        chk("model_busy",  {63'd0, busy},             {63'd0, m_busy});
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          a;
        bit          ready, req, done, bsy;
        logic [31:0] data;
    } vec_t;

    function automatic vec_t mk(bit v, logic [31:0] d, bit a,
                                bit ready, bit req, logic [31:0] data, bit done, bit bsy);
        vec_t x;
        x.v = v; x.d = d; x.a = a;
        x.ready = ready; x.req = req; x.data = data; x.done = done; x.bsy = bsy;
        return x;
    endfunction

    // Responder used as stimulus: follows cdc_req after r_dly cycles.
    bit r_ack;
    int r_cnt, r_dly;

    task automatic resp_next();
        if (cdc_req != r_ack) begin
            if (r_cnt >= r_dly) begin r_ack = cdc_req; r_cnt = 0; end
            else r_cnt++;
        end else r_cnt = 0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] words [3];
        int idx, dones, n;

        src_if.src_valid = 0;
        src_if.src_data  = '0;
        cdc_ack          = 0;
        model_reset();
        @(negedge clk);
        chk("rst_ready", {63'd0, src_if.src_ready}, 64'd1);
        chk("rst_req",   {63'd0, cdc_req},          64'd0);
        chk("rst_busy",  {63'd0, busy},             64'd0);
        @(negedge clk);
        rstn = 1;

        // spurious ack while idle, settle, then a single transfer with junk data while busy
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hA5A5_1234, 0, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 1, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(1, 32'h1111_1111, 0, 0, 1, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             1, 0, 1, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(1, 32'h2222_2222, 1, 0, 1, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             1, 0, 1, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             1, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(1, 32'h3333_3333, 0, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 0, 32'hA5A5_1234, 0, 1));
        tbl.push_back(mk(0, 0,             0, 1, 0, 32'hA5A5_1234, 1, 0));
        tbl.push_back(mk(0, 0,             0, 1, 0, 32'hA5A5_1234, 0, 0));
        tbl.push_back(mk(1, 32'h0000_0042, 0, 0, 0, 32'h0000_0042, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 32'h0000_0042, 0, 1));

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].a);
            chk($sformatf("tbl%0d_ready", i), {63'd0, src_if.src_ready}, {63'd0, tbl[i].ready});
            chk($sformatf("tbl%0d_req", i),   {63'd0, cdc_req},          {63'd0, tbl[i].req});
            chk($sformatf("tbl%0d_data", i),  {32'd0, cdc_data},         {32'd0, tbl[i].data});
            chk($sformatf("tbl%0d_done", i),  {63'd0, tx_done},          {63'd0, tbl[i].done});
            chk($sformatf("tbl%0d_busy", i),  {63'd0, busy},             {63'd0, tbl[i].bsy});
        end

        // asynchronous reset while in REQ
        #2 rstn = 0;
        #1;
        chk("async_req",   {63'd0, cdc_req},          64'd0);
        chk("async_data",  {32'd0, cdc_data},         64'd0);
        chk("async_ready", {63'd0, src_if.src_ready}, 64'd1);
        chk("async_busy",  {63'd0, busy},             64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);
        chk("stale_req",  {63'd0, cdc_req}, 64'd0);
        chk("stale_busy", {63'd0, busy},    64'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // back-to-back words with a 2-cycle responder
        words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3;
        r_ack = 0; r_cnt = 0; r_dly = 2;
        idx = 0; dones = 0;
        for (int t = 0; t < 200 && dones < 3; t++) begin
            bit v, acc;
            resp_next();
            v   = (idx < 3);
            acc = v && !m_busy;
            cycle(v, v ? words[idx] : 32'd0, r_ack);
            if (acc) idx++;
            if (tx_done) begin
                chk("b2b_word", {32'd0, cdc_data}, {32'd0, words[dones]});
                dones++;
            end
        end
        chk("b2b_done_cnt", 64'(dones), 64'd3);
        chk("b2b_accepts",  64'(idx),   64'd3);
        for (int i = 0; i < 10; i++) begin resp_next(); cycle(0, 0, r_ack); end

        // slow ack held for 100 cycles
        cycle(1, 32'hCAFE_0001, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 100; i++) cycle(1, $urandom, 1);
        chk("slow_req",   {63'd0, cdc_req},          64'd0);
        chk("slow_ready", {63'd0, src_if.src_ready}, 64'd0);
        chk("slow_busy",  {63'd0, busy},             64'd1);
        chk("slow_data",  {32'd0, cdc_data},         {32'd0, 32'hCAFE_0001});
        n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
        end while (!tx_done && n < 10);
        chk("slow_idle_edges", 64'(n), 64'd4);
        chk("slow_busy_after", {63'd0, busy}, 64'd0);

        // randomized traffic with random responder delay and idle ack glitches
        r_ack = 0; r_cnt = 0; r_dly = 0;
        for (int t = 0; t < 3000; t++) begin
            bit a;
            if (!m_busy) r_dly = $urandom_range(0, 4);
            resp_next();
            a = r_ack;
            if (!m_busy && !r_ack && $urandom_range(0, 15) == 0) a = 1'b1;
            cycle($urandom_range(0, 2) != 0, $urandom, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
